ps2_kbd_rx: RTL and testbench

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

---
 rtl/ps2_kbd_rx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_rx
// Description : PS/2 keyboard receiver with glitch filter, frame checker,
//               E0/F0 prefix decoder and an event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
    parameter int ADDR_W  = 3,
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 50000,
    parameter int DECODE  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    input  logic            read,
    output logic [9:0]      data,
    output logic            ready,
    output logic [ADDR_W:0] count,
    output logic            overflow,
    output logic            frame_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic [1:0]        clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic              filt_q, filt_d, strobe_q, strobe_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic [0:0]        state_q, state_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic              frame_err_q, frame_err_d;
    logic              ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [9:0]        mem_q [DEPTH];

    logic       sbit, timeout, byte_ok, push, pop, full, wr_en;
    logic [9:0] push_data;

    assign sbit    = dat_sync_q[1];
    assign timeout = (idle_q == TW'(TIMEOUT));

    // A level change is accepted only after FILTER consecutive mismatching samples.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        filt_d     = filt_q;
        fcnt_d     = '0;
        strobe_d   = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == 4'(FILTER - 1)) begin
                filt_d   = clk_sync_q[1];
                strobe_d = ~clk_sync_q[1];
            end else begin
                fcnt_d = fcnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (strobe_q && !sbit) state_d = ST_RECV;
            ST_RECV: if ((strobe_q && bit_idx_q == 4'd10) || (!strobe_q && timeout))
                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        idle_d      = '0;
        frame_err_d = frame_err_q;
        byte_ok     = 1'b0;
        case (state_q)
            ST_IDLE: if (strobe_q && !sbit) bit_idx_d = 4'd1;
            ST_RECV: begin
                if (strobe_q) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q <= 4'd8) shift_d = {sbit, shift_q[7:1]};
                    if (bit_idx_q == 4'd9) par_d = sbit;
                    if (bit_idx_q == 4'd10) begin
                        bit_idx_d = '0;
                        if (sbit && (^{shift_q, par_q})) byte_ok     = 1'b1;
                        else                             frame_err_d = 1'b1;
                    end
                end else if (timeout) begin
                    bit_idx_d   = '0;
                    frame_err_d = 1'b1;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
        endcase
    end

    // Prefix bytes only arm flags; the following byte carries them into the FIFO.
    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        push       = 1'b0;
        push_data  = '0;
        if (byte_ok) begin
            if (DECODE != 0 && shift_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (DECODE != 0 && shift_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                push       = 1'b1;
                push_data  = (DECODE != 0) ? {ext_pend_q, brk_pend_q, shift_q}
                                           : {2'b00, shift_q};
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
    end

    always_comb begin
        pop        = read && (count_q != '0);
        full       = (count_q == (ADDR_W+1)'(DEPTH));
        wr_en      = push && (!full || pop);
        wr_ptr_d   = wr_ptr_q + ADDR_W'(wr_en);
        rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
        count_d    = count_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
        overflow_d = overflow_q | (push & full & ~pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            strobe_q    <= 1'b0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            idle_q      <= '0;
            frame_err_q <= 1'b0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            strobe_q    <= strobe_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            idle_q      <= idle_d;
            frame_err_q <= frame_err_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    assign ready     = (count_q != '0);
    assign data      = ready ? mem_q[rd_ptr_q] : 10'h000;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_kbd_rx
// Description : Self-checking bench for ps2_kbd_rx, decoded and raw instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;
    localparam int ADDR_W  = 3;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int FILTER  = 4;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 20;

    logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic       read = 1'b0, read_r = 1'b0;
    logic [9:0] data, data_r;
    logic       ready, ready_r, overflow, overflow_r, frame_err, frame_err_r;
    logic [ADDR_W:0] count, count_r;

    int n_tests = 0, n_fail = 0;

    // Reference model: decoded queue, raw queue, pending prefixes, sticky flags.
    logic [9:0] mq[$];
    logic [9:0] rq[$];
    logic m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0, r_ovf = 1'b0, m_err = 1'b0;

    ps2_kbd_rx #(.ADDR_W(ADDR_W), .FILTER(FILTER), .TIMEOUT(TIMEOUT), .DECODE(1)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .read(read),
        .data(data), .ready(ready), .count(count), .overflow(overflow), .frame_err(frame_err));

    ps2_kbd_rx #(.ADDR_W(ADDR_W), .FILTER(FILTER), .TIMEOUT(TIMEOUT), .DECODE(0)) dut_raw (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .read(read_r),
        .data(data_r), .ready(ready_r), .count(count_r), .overflow(overflow_r),
        .frame_err(frame_err_r));

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_frame(input logic [7:0] b, input logic ok);
        if (!ok) begin
            m_err = 1'b1;
            return;
        end
        if (rq.size() < DEPTH) rq.push_back({2'b00, b});
        else r_ovf = 1'b1;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
            else m_ovf = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    task automatic ps2_bit(input logic b, input bit glitch);
        @(negedge clk) ps2_data = b;
        if (glitch) begin
            repeat (8) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (FILTER - 1) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - 8 - (FILTER - 1)) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_idx);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i], i == glitch_idx);
        repeat (HALF) @(negedge clk);
        model_frame(b, !bad_par);
    endtask

    task automatic check_flags(input string tag);
        n_tests++;
        if (frame_err !== m_err || frame_err_r !== m_err) begin
            n_fail++;
            $display("FAIL %s frame_err: got %b/%b want %b", tag, frame_err, frame_err_r, m_err);
        end
        n_tests++;
        if (overflow !== m_ovf || overflow_r !== r_ovf) begin
            n_fail++;
            $display("FAIL %s overflow: got %b/%b want %b/%b", tag, overflow, overflow_r, m_ovf, r_ovf);
        end
    endtask

    // Pops every expected entry from both instances, comparing head and occupancy.
    task automatic drain(input string tag);
        while (mq.size() > 0) begin
            n_tests++;
            if (data !== mq[0] || count !== (ADDR_W+1)'(mq.size())) begin
                n_fail++;
                $display("FAIL %s dec head: got %h cnt %0d want %h cnt %0d",
                         tag, data, count, mq[0], mq.size());
            end
            read = 1'b1;
            @(negedge clk) read = 1'b0;
            void'(mq.pop_front());
        end
        while (rq.size() > 0) begin
            n_tests++;
            if (data_r !== rq[0] || count_r !== (ADDR_W+1)'(rq.size())) begin
                n_fail++;
                $display("FAIL %s raw head: got %h cnt %0d want %h cnt %0d",
                         tag, data_r, count_r, rq[0], rq.size());
            end
            read_r = 1'b1;
            @(negedge clk) read_r = 1'b0;
            void'(rq.pop_front());
        end
        n_tests++;
        if (ready !== 1'b0 || ready_r !== 1'b0 || count !== '0 || count_r !== '0 ||
            data !== 10'h000 || data_r !== 10'h000) begin
            n_fail++;
            $display("FAIL %s empty: got rdy %b/%b cnt %0d/%0d data %h/%h want 0",
                     tag, ready, ready_r, count, count_r, data, data_r);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (ready !== 1'b0 || data !== 10'h000 || count !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got rdy %b data %h cnt %0d want 0 0 0", ready, data, count);
        end
        check_flags("reset");
    endtask

    task automatic test_single;
        send_frame(8'h1C, 1'b0, -1);
        n_tests++;
        if (ready !== 1'b1 || data !== 10'h01C || count !== 4'd1) begin
            n_fail++;
            $display("FAIL single: got rdy %b data %h cnt %0d want 1 01c 1", ready, data, count);
        end
        read = 1'b1;
        @(negedge clk) read = 1'b0;
        void'(mq.pop_front());
        n_tests++;
        if (ready !== 1'b0 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL single_pop: got rdy %b cnt %0d want 0 0", ready, count);
        end
        drain("single");
    endtask

    task automatic test_read_empty;
        read = 1'b1;
        read_r = 1'b1;
        repeat (3) @(negedge clk);
        read = 1'b0;
        read_r = 1'b0;
        n_tests++;
        if (count !== '0 || ready !== 1'b0 || count_r !== '0) begin
            n_fail++;
            $display("FAIL read_empty: got cnt %0d/%0d rdy %b want 0", count, count_r, ready);
        end
    endtask

    task automatic test_prefix;
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'hF0, 1'b0, -1);
        send_frame(8'h75, 1'b0, -1);
        n_tests++;
        if (count !== 4'd1 || data !== 10'h375) begin
            n_fail++;
            $display("FAIL prefix_dec: got cnt %0d data %h want 1 375", count, data);
        end
        n_tests++;
        if (count_r !== 4'd3 || data_r !== 10'h0E0) begin
            n_fail++;
            $display("FAIL prefix_raw: got cnt %0d data %h want 3 0e0", count_r, data_r);
        end
        drain("prefix");
    endtask

    task automatic test_parity;
        send_frame(8'h1C, 1'b1, -1);
        send_frame(8'h32, 1'b0, -1);
        n_tests++;
        if (count !== 4'd1 || data !== 10'h032 || frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL parity: got cnt %0d data %h err %b want 1 032 1", count, data, frame_err);
        end
        check_flags("parity");
        drain("parity");
    endtask

    task automatic test_timeout;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        mq.delete(); rq.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; r_ovf = 0; m_err = 0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : logic'($urandom_range(0, 1)), 1'b0);
        repeat (TIMEOUT + 10) @(negedge clk);
        m_err = 1'b1;
        n_tests++;
        if (frame_err !== 1'b1 || count !== '0) begin
            n_fail++;
            $display("FAIL timeout_abort: got err %b cnt %0d want 1 0", frame_err, count);
        end
        send_frame(8'h29, 1'b0, -1);
        n_tests++;
        if (count !== 4'd1 || data !== 10'h029) begin
            n_fail++;
            $display("FAIL timeout_next: got cnt %0d data %h want 1 029", count, data);
        end
        check_flags("timeout");
        drain("timeout");
    endtask

    task automatic test_glitch;
        logic [7:0] b;
        for (int k = 0; k < 2; k++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hE0 || b == 8'hF0) b = 8'h5A;
            send_frame(b, 1'b0, 3 + 3 * k);
            n_tests++;
            if (count !== 4'd1 || data !== {2'b00, b}) begin
                n_fail++;
                $display("FAIL glitch: got cnt %0d data %h want 1 %h", count, data, {2'b00, b});
            end
            drain("glitch");
        end
    endtask

    task automatic test_overflow;
        logic [7:0] b;
        logic [7:0] used[$];
        for (int i = 0; i < DEPTH + 1; i++) begin
            do begin
                b = 8'($urandom_range(0, 255));
            end while (b == 8'hE0 || b == 8'hF0 || (b inside {used}));
            used.push_back(b);
            send_frame(b, 1'b0, -1);
        end
        n_tests++;
        if (count !== 4'(DEPTH) || overflow !== 1'b1 || count_r !== 4'(DEPTH)) begin
            n_fail++;
            $display("FAIL overflow: got cnt %0d/%0d ovf %b want %0d 1", count, count_r, overflow, DEPTH);
        end
        check_flags("overflow");
        drain("overflow");
    endtask

    task automatic test_random;
        logic [7:0] b;
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 2) == 0) send_frame(8'hE0, 1'b0, -1);
            if ($urandom_range(0, 2) == 0) send_frame(8'hF0, 1'b0, -1);
            do b = 8'($urandom_range(0, 255)); while (b == 8'hE0 || b == 8'hF0);
            send_frame(b, $urandom_range(0, 4) == 0, -1);
            check_flags("random");
            drain("random");
        end
    endtask

    task automatic test_reset_midframe;
        for (int i = 0; i < 4; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1, 1'b0);
        @(negedge clk) ps2_clk = 1'b0;
        #2 rst = 1'b1;
        mq.delete(); rq.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; r_ovf = 0; m_err = 0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (HALF) @(negedge clk);
        n_tests++;
        if (count !== '0 || ready !== 1'b0 || frame_err !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset: got cnt %0d rdy %b err %b ovf %b want 0",
                     count, ready, frame_err, overflow);
        end
        send_frame(8'h4B, 1'b0, -1);
        n_tests++;
        if (count !== 4'd1 || data !== 10'h04B || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_next: got cnt %0d data %h err %b want 1 04b 0", count, data, frame_err);
        end
        drain("midframe");
    endtask

    initial begin
        test_reset;
        test_single;
        test_read_empty;
        test_prefix;
        test_parity;
        test_glitch;
        test_random;
        test_timeout;
        test_overflow;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
